// File: rtl/oam_dma.sv
// oam_dma: sprite-RAM DMA initiator sitting between the CPU core and mem_ctrl.
// A CPU write to $4014 with page P copies CPU addresses P<<8 .. (P<<8)+$FF
// into the OAM data port ($2004) while holding the CPU stalled. When idle,
// CPU accesses pass straight through to mem_ctrl.
// Optional feature: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle before
// START whenever the free-running parity bit is 1 at the trigger edge.
module oam_dma (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_write_en,
   input  logic        cpu_read_en,
   output logic        cpu_stall,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data_out,
   output logic        mem_write_en,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_in,
   input  logic        mem_busy,
   output logic        dma_active
);

   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_DATA = 16'h2004;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START   = 3'd1;
   localparam logic [2:0] READ    = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] WRITE   = 3'd4;
`ifdef OAM_DMA_ALIGN_EN
   localparam logic [2:0] ALIGN   = 3'd5;
`endif

   logic [2:0] state;
   logic [2:0] state_next;
   logic [7:0] page;
   logic [8:0] idx;
   logic [8:0] idx_inc;
   logic [7:0] latch;
   logic       parity;
   logic       trigger;
   logic       unused_bits;

   assign trigger     = (state == IDLE) && cpu_write_en && (cpu_addr_in == DMA_REG);
   assign idx_inc     = idx + 9'd1;
   assign cpu_stall   = (state != IDLE);
   assign dma_active  = (state != IDLE);
   assign unused_bits = ^{parity, idx[8]};

   // Next-state selection; bus stages hold while mem_ctrl reports busy.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
`ifdef OAM_DMA_ALIGN_EN
            if (trigger) state_next = parity ? ALIGN : START;
`else
            if (trigger) state_next = START;
`endif
         end
`ifdef OAM_DMA_ALIGN_EN
         ALIGN:   state_next = START;
`endif
         START:   state_next = READ;
         READ:    if (!mem_busy) state_next = CAPTURE;
         CAPTURE: if (!mem_busy) state_next = WRITE;
         WRITE:   if (!mem_busy) state_next = idx_inc[8] ? IDLE : READ;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset always wins over a simultaneous trigger.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Transfer registers: page/index captured on trigger, read data latched in CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         page  <= 8'h00;
         idx   <= 9'd0;
         latch <= 8'h00;
      end else begin
         if (trigger) begin
            page <= cpu_data_in;
            idx  <= 9'd0;
         end
         if ((state == CAPTURE) && !mem_busy) latch <= mem_data_in;
         if ((state == WRITE) && !mem_busy)   idx   <= idx_inc;
      end
   end

   // Free-running parity toggle used to decide on the alignment cycle.
   always_ff @(posedge clk) begin
      if (rst) parity <= 1'b0;
      else     parity <= ~parity;
   end

   // Bus drive: passthrough when idle (minus $4014 writes), DMA strobes otherwise.
   always_comb begin
      mem_addr     = {page, idx[7:0]};
      mem_data_out = latch;
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
      case (state)
         IDLE: begin
            mem_addr     = cpu_addr_in;
            mem_data_out = cpu_data_in;
            mem_write_en = cpu_write_en && (cpu_addr_in != DMA_REG);
            mem_read_en  = cpu_read_en;
         end
         READ, CAPTURE: begin
            mem_read_en = 1'b1;
         end
         WRITE: begin
            mem_addr     = OAM_DATA;
            mem_write_en = 1'b1;
         end
         default: begin
            mem_write_en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma. A transaction-level
// model tracks how many stalled cycles remain and which byte is due next,
// and a bench-side mem_ctrl (CPU memory image plus OAM pointer/SPRAM) serves
// the reads and absorbs the writes.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr_in;
   logic [7:0]  cpu_data_in;
   logic        cpu_write_en;
   logic        cpu_read_en;
   logic        cpu_stall;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [7:0]  mem_data_in;
   logic        mem_busy;
   logic        dma_active;

   oam_dma dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr_in  (cpu_addr_in),
      .cpu_data_in  (cpu_data_in),
      .cpu_write_en (cpu_write_en),
      .cpu_read_en  (cpu_read_en),
      .cpu_stall    (cpu_stall),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_write_en (mem_write_en),
      .mem_read_en  (mem_read_en),
      .mem_data_in  (mem_data_in),
      .mem_busy     (mem_busy),
      .dma_active   (dma_active)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   logic [7:0] mem_img [0:65535];
   logic [7:0] spram   [0:255];
   logic [7:0] oam_ptr = 8'h00;

   assign mem_data_in = mem_img[mem_addr];

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;

   bit         m_par        = 1'b0;
   int         m_pre        = 0;
   int         m_work       = 0;
   logic [7:0] m_page       = 8'h00;
   int         wr_n         = 0;
   int         stall_cycles = 0;
   int         writes_2004  = 0;
   int         rd_out       = 0;

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transfer model: a trigger owes 1 (or 2 when aligning) unconditional
   // cycles plus 768 bus cycles, and a bus cycle is only spent when not busy.
   always @(posedge clk) begin
      if (rst) begin
         armed  = 1'b1;
         m_par  = 1'b0;
         m_pre  = 0;
         m_work = 0;
      end else begin
         if ((m_pre > 0) || (m_work > 0)) begin
            if (m_pre > 0)      m_pre--;
            else if (!mem_busy) m_work--;
         end else if (cpu_write_en && (cpu_addr_in == 16'h4014)) begin
            m_page       = cpu_data_in;
            m_pre        = (ALIGN_EN && m_par) ? 2 : 1;
            m_work       = 768;
            wr_n         = 0;
            stall_cycles = 0;
            rd_out       = 0;
         end
         m_par = ~m_par;
      end
   end

   task automatic checkOutput();
      bit exp_stall;
      exp_stall = (m_pre > 0) || (m_work > 0);
      checkValue("cpu_stall", cpu_stall, exp_stall);
      checkValue("dma_active", dma_active, exp_stall);
      if (!exp_stall) begin
         checkValue("pass_addr", mem_addr, cpu_addr_in);
         checkValue("pass_data", mem_data_out, cpu_data_in);
         checkValue("pass_read_en", mem_read_en, cpu_read_en);
         checkValue("pass_write_en", mem_write_en, cpu_write_en && (cpu_addr_in != 16'h4014));
      end else begin
         stall_cycles++;
         if (m_pre > 0) begin
            checkValue("pre_read_en", mem_read_en, 1'b0);
            checkValue("pre_write_en", mem_write_en, 1'b0);
         end
         checkValue("strobe_excl", mem_read_en & mem_write_en, 1'b0);
         if (mem_read_en) begin
            checkValue("read_addr", mem_addr, {m_page, wr_n[7:0]});
            if (mem_addr[15:8] != m_page) rd_out++;
         end
         if (mem_write_en) begin
            checkValue("write_addr", mem_addr, 16'h2004);
            if (!mem_busy) begin
               checkValue("write_data", mem_data_out, mem_img[{m_page, wr_n[7:0]}]);
               wr_n++;
            end
         end
      end
      if (!rst && mem_write_en && !mem_busy) begin
         if (mem_addr == 16'h2004) begin
            spram[oam_ptr] = mem_data_out;
            oam_ptr        = oam_ptr + 8'd1;
            writes_2004++;
         end else if (mem_addr == 16'h2003) begin
            oam_ptr = mem_data_out;
         end
      end
   endtask

   // Per-cycle compare, sampled mid low phase once reset has been seen.
   always @(negedge clk) begin
      #3;
      if (armed) checkOutput();
   end

   task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                input logic we, input logic re, input logic busy);
      @(negedge clk);
      cpu_addr_in  = a;
      cpu_data_in  = d;
      cpu_write_en = we;
      cpu_read_en  = re;
      mem_busy     = busy;
   endtask

   task automatic waitDone(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if (!cpu_stall) begin
            done = 1'b1;
            break;
         end
      end
      checkValue("done_timeout", done, 1'b1);
   endtask

   task automatic startDma(input logic [7:0] p);
      applyStimulus(16'h2003, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h4014, p, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkSpram(input logic [7:0] p);
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         a = {p, i[7:0]};
         checkValue("spram_byte", spram[i], mem_img[a]);
      end
   endtask

   initial begin
      int w0;
      int c;
      bit found;
      logic [15:0] na;
      logic [7:0]  rp;

      rst          = 1'b1;
      cpu_addr_in  = 16'h0000;
      cpu_data_in  = 8'h00;
      cpu_write_en = 1'b0;
      cpu_read_en  = 1'b0;
      mem_busy     = 1'b0;
      for (int i = 0; i < 65536; i++) mem_img[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
         mem_img[16'h0200 + i] = 8'(i) ^ 8'h5A;
         spram[i] = 8'h00;
      end

      $display("[TB] reset");
      repeat (3) applyStimulus(16'h0123, 8'hAB, 1'b1, 1'b0, 1'b0);
      #3;
      checkValue("rst_stall", cpu_stall, 1'b0);
      checkValue("rst_active", dma_active, 1'b0);
      checkValue("rst_pass_addr", mem_addr, 16'h0123);
      checkValue("rst_pass_we", mem_write_en, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("[TB] basic transfer");
      w0 = writes_2004;
      startDma(8'h02);
      waitDone(1000);
      checkValue("basic_stall_len", stall_cycles, 769);
      checkValue("basic_writes", writes_2004 - w0, 256);
      for (int i = 0; i < 256; i++) checkValue("basic_spram", spram[i], 8'(i) ^ 8'h5A);

      $display("[TB] busy stretch");
      w0 = writes_2004;
      startDma(8'h02);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (mem_read_en && (mem_addr == 16'h020A)) begin
            found = 1'b1;
            break;
         end
      end
      checkValue("busy_find_byte10", found, 1'b1);
      repeat (4) applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
      waitDone(1000);
      checkValue("busy_stall_len", stall_cycles, 773);
      checkValue("busy_writes", writes_2004 - w0, 256);
      checkValue("busy_byte10", spram[10], 8'h50);
      for (int i = 0; i < 256; i++) checkValue("busy_spram", spram[i], 8'(i) ^ 8'h5A);

      $display("[TB] retrigger and isolation");
      w0 = writes_2004;
      startDma(8'h02);
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #4;
         if (wr_n >= 50) begin
            found = 1'b1;
            break;
         end
      end
      checkValue("retrig_find_byte50", found, 1'b1);
      applyStimulus(16'h4014, 8'h07, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0000, 8'h99, 1'b1, 1'b0, 1'b0);
      #3;
      checkValue("cpu_write_blocked", mem_write_en && (mem_addr == 16'h0000), 1'b0);
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
      waitDone(1000);
      checkValue("retrig_stall_len", stall_cycles, 769);
      checkValue("retrig_writes", writes_2004 - w0, 256);
      for (int i = 0; i < 256; i++) checkValue("retrig_spram", spram[i], 8'(i) ^ 8'h5A);

      $display("[TB] reset mid transfer");
      w0 = writes_2004;
      startDma(8'h02);
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         #4;
         if (wr_n >= 100) begin
            found = 1'b1;
            break;
         end
      end
      checkValue("reset_find_byte100", found, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #3;
      checkValue("reset_stall_drop", cpu_stall, 1'b0);
      repeat (6) applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
      #3;
      checkValue("reset_stall_after", cpu_stall, 1'b0);
      checkValue("reset_writes", writes_2004 - w0, 100);

      $display("[TB] page FF, odd parity trigger");
      w0 = writes_2004;
      applyStimulus(16'h2003, 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (!m_par) @(negedge clk);
      cpu_addr_in  = 16'h4014;
      cpu_data_in  = 8'hFF;
      cpu_write_en = 1'b1;
      cpu_read_en  = 1'b0;
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
      waitDone(1000);
      checkValue("pageff_stall_len", stall_cycles, ALIGN_EN ? 770 : 769);
      checkValue("pageff_writes", writes_2004 - w0, 256);
      checkValue("pageff_rd_out", rd_out, 0);
      checkSpram(8'hFF);

      $display("[TB] random passthrough");
      for (int k = 0; k < 40; k++) begin
         na = 16'($urandom_range(0, 16'h1FFF));
         applyStimulus(na, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
      applyStimulus(16'h4014, 8'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("[TB] random transfers");
      for (int t = 0; t < 4; t++) begin
         rp = 8'($urandom);
         w0 = writes_2004;
         startDma(rp);
         c = 0;
         do begin
            na = 16'($urandom_range(0, 16'h1FFF));
            if ((m_work > 10) && ($urandom_range(0, 15) == 0)) na = 16'h4014;
            applyStimulus(na, 8'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0));
            c++;
         end while (cpu_stall && (c < 3000));
         applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
         checkValue("rand_timeout", (c < 3000), 1'b1);
         checkValue("rand_writes", writes_2004 - w0, 256);
         checkSpram(rp);
         repeat (3) applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-RAM DMA initiator for the CPU bus. A CPU write to $4014 with page value P starts the transfer: the block stalls the CPU, reads CPU addresses P<<8 through (P<<8)+$FF via `mem_ctrl`, and writes each byte to $2004, the OAM data port. It sits between the CPU core and `mem_ctrl` and owns the `mem_ctrl` CPU-side port while active. When idle it passes CPU accesses straight through.

## Interface
- No parameters.
- Reset is synchronous, active-high.
- Ports:
  - `clk` in 1: system clock, rising edge.
  - `rst` in 1: synchronous active-high reset.
  - `cpu_addr_in` in 16: CPU address.
  - `cpu_data_in` in 8: CPU write data.
  - `cpu_write_en` in 1: CPU write strobe.
  - `cpu_read_en` in 1: CPU read strobe.
  - `cpu_stall` out 1: halts the CPU while DMA owns the bus.
  - `mem_addr` out 16: address to `mem_ctrl` `cpu_addr_in`.
  - `mem_data_out` out 8: write data to `mem_ctrl` `cpu_data_in`.
  - `mem_write_en` out 1: write strobe to `mem_ctrl`.
  - `mem_read_en` out 1: read strobe to `mem_ctrl`.
  - `mem_data_in` in 8: `mem_ctrl` `cpu_data_out`.
  - `mem_busy` in 1: `mem_ctrl` busy.
  - `dma_active` out 1: high in every non-IDLE state.

## Operation
- States: IDLE, START, READ, CAPTURE, WRITE. ALIGN exists only with the macro.
- Registers:
  - `page` (8b), latched from `cpu_data_in` on trigger.
  - `idx` (9b) byte counter; bit 8 set means done.
  - `latch` (8b) read data.
  - `parity` (1b), free-running toggle.
- Trigger: in IDLE, at a `clk` edge with `cpu_write_en`=1 and `cpu_addr_in`=$4014.
  - Latch `page`, clear `idx`, go to START.
  - The $4014 write is not forwarded to `mem_ctrl`.
- IDLE passthrough: all `mem_*` outputs equal the corresponding `cpu_*` inputs (combinational), except suppressed $4014 writes.
- START: one cycle, no strobes. Goes to READ.
- READ: `mem_addr` = {`page`, `idx`[7:0]}, `mem_read_en`=1. Goes to CAPTURE.
- CAPTURE:
  - `mem_addr` is held and `mem_read_en`=1.
  - At the edge, `latch` <= `mem_data_in`.
  - Goes to WRITE.
- WRITE: `mem_addr`=$2004, `mem_data_out`=`latch`, `mem_write_en`=1.
  - At the edge, `idx` <= `idx`+1.
  - If `idx` was $FF, go to IDLE; else go to READ.
- Busy: in READ, CAPTURE or WRITE, `mem_busy`=1 freezes the state, counters and `latch`. Strobes and address stay asserted.
- While non-IDLE:
  - CPU strobes are ignored and not forwarded.
  - A new $4014 write is ignored; it does not restart or change `page`.
- Page wrap: `idx` wraps only the low byte of the address. Page $FF reads $FF00–$FFFF and never carries into the page.
- OAM pointer: the block never writes $2003. Bytes land starting at the current OAM pointer, and `mem_ctrl` auto-increment handles placement.

## Timing
- Reset values:
  - `cpu_stall`, `dma_active`, `mem_write_en`, `mem_read_en` = 0.
  - `mem_addr`, `mem_data_out` show passthrough of the CPU inputs.
  - State IDLE; `page`, `idx`, `latch`, `parity` = 0.
- Reset mid-transfer: state returns to IDLE on the reset edge. No further $2004 write is issued, and `cpu_stall` drops the cycle after.
- Trigger at edge k:
  - `cpu_stall`=1 from cycle k+1.
  - First read strobe in cycle k+2.
- Each byte takes 3 cycles plus any `mem_busy` cycles.
- Stall length with `mem_busy`=0: 769 cycles (START + 768).
- `cpu_stall` is 0 in the cycle after the final WRITE edge; the CPU resumes then.
- Simultaneous reset and trigger: reset wins.

## Configuration
- `OAM_DMA_ALIGN_EN` defined:
  - If `parity`=1 at the trigger edge, insert one ALIGN cycle before START (no strobes, stall high).
  - Stall is then 770 cycles; it stays 769 when `parity`=0.
- Undefined: no ALIGN state; stall is always 769 cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles.
  - `cpu_stall`=0, `dma_active`=0.
  - With `cpu_addr_in`=$0123, `cpu_write_en`=1: `mem_addr`=$0123 and `mem_write_en`=1 (passthrough).
- Basic transfer: preload $0200+i = i^$5A, set OAM pointer to $00, write $02 to $4014.
  - Exactly 256 writes to $2004, with data $5A,$5B,…
  - PPU-side SPRAM reads at addresses 0–255 return i^$5A.
  - `cpu_stall` high for 769 cycles.
- Busy stretch: hold `mem_busy`=1 for 4 cycles during the CAPTURE of byte 10.
  - Stall grows to 773 cycles.
  - Byte 10 is correct and no duplicate write occurs.
- Retrigger and CPU isolation during transfer:
  - Write $07 to $4014 at byte 50: ignored, and `page` stays $02.
  - A CPU write to $0000 is not forwarded.
- Reset at byte 100:
  - IDLE on the next cycle; exactly 100 $2004 writes were observed.
  - `cpu_stall`=0 thereafter.
- Page $FF with `OAM_DMA_ALIGN_EN` and odd-parity trigger:
  - Reads cover $FF00–$FFFF only.
  - Stall is 770 cycles.
